// File: rtl/fp_pkg.sv
// Shared floating-point definitions: divider state encoding, exception bit
// positions, operand class bundle and canonical special-value constants.
package fp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_NORM,
    ST_DIVIDE,
    ST_ROUND
  } state_e;

  localparam int EXC_INVALID   = 4;
  localparam int EXC_DIV_ZERO  = 3;
  localparam int EXC_OVERFLOW  = 2;
  localparam int EXC_UNDERFLOW = 1;
  localparam int EXC_INEXACT   = 0;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic is_sub;
  } fp_class_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_INF,
    FP_QNAN
  } fp_kind_e;

  // Wide enough for any format we instantiate; callers slice off their width.
  localparam int FP_MAX_W = 128;

  // Positive canonical special value for the given field widths (sign bit 0).
  function automatic logic [FP_MAX_W-1:0] fp_const(input fp_kind_e kind,
                                                   input int exp_w,
                                                   input int man_w);
    logic [FP_MAX_W-1:0] one;
    logic [FP_MAX_W-1:0] exp_ones;
    one      = {{(FP_MAX_W-1){1'b0}}, 1'b1};
    exp_ones = ((one << exp_w) - one) << man_w;
    case (kind)
      FP_INF:  return exp_ones;
      FP_QNAN: return exp_ones | (one << (man_w - 1));
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/fpdiv_param_if.sv
// Request/response bundle of the divider: operands and START in, quotient,
// flags and DONE/BUSY back.
interface fpdiv_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         START;
  logic [W-1:0] InputA;
  logic [W-1:0] InputB;
  logic [W-1:0] AbyB;
  logic         DONE;
  logic         BUSY;
  logic [4:0]   EXCEPTION;

  modport master (output START, InputA, InputB,
                  input  AbyB, DONE, BUSY, EXCEPTION);
  modport slave  (input  START, InputA, InputB,
                  output AbyB, DONE, BUSY, EXCEPTION);
endinterface

// File: rtl/fp_classify.sv
// Combinational operand classifier; takes the magnitude (exponent+mantissa)
// since the sign never affects the class.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] mag,
  output fp_class_t              cls
);
  logic exp_ones;
  logic exp_zero;
  logic man_zero;

  assign exp_ones = &mag[EXP_W+MAN_W-1:MAN_W];
  assign exp_zero = ~|mag[EXP_W+MAN_W-1:MAN_W];
  assign man_zero = ~|mag[MAN_W-1:0];

  assign cls.is_nan  = exp_ones & ~man_zero;
  assign cls.is_inf  = exp_ones &  man_zero;
  assign cls.is_zero = exp_zero &  man_zero;
  assign cls.is_sub  = exp_zero & ~man_zero;
endmodule

// File: rtl/fpdiv_param.sv
// Sequential IEEE-754 divider, one restoring-division quotient bit per cycle,
// round-to-nearest-even; subnormal inputs are normalised, tiny results flush to zero.
module fpdiv_param
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic          CLOCK,
  input logic          RESET_N,
  fpdiv_param_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int QW = MAN_W + 4;
  localparam int CW = $clog2(QW);

  localparam logic [CW-1:0]        LAST_STEP = CW'(QW - 1);
  localparam logic signed [EW-1:0] E_ONE     = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO    = '0;
  localparam logic signed [EW-1:0] BIAS      = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_MAX     = EW'((1 << EXP_W) - 1);

  localparam logic [FP_MAX_W-1:0] INF_WORD  = fp_const(FP_INF, EXP_W, MAN_W);
  localparam logic [FP_MAX_W-1:0] QNAN_WORD = fp_const(FP_QNAN, EXP_W, MAN_W);
  localparam logic [W-2:0]        INF_MAG   = INF_WORD[W-2:0];
  localparam logic [W-1:0]        QNAN      = QNAN_WORD[W-1:0];

  state_e                 state;
  logic [W-1:0]           a_q, b_q;
  logic                   sign_q;
  logic [MAN_W:0]         ma, mb;
  logic signed [EW-1:0]   ea, eb, e_q;
  logic [MAN_W+1:0]       rem;
  logic [QW-1:0]          quo;
  logic [CW-1:0]          cnt;
  logic [W-1:0]           res_q;
  logic [4:0]             exc_q;
  logic                   done_q, busy_q;

  fp_class_t cls_a, cls_b;
  logic      sign_ab;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.mag(a_q[W-2:0]), .cls(cls_a));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.mag(b_q[W-2:0]), .cls(cls_b));

  assign sign_ab = a_q[W-1] ^ b_q[W-1];

  // Special-case resolution, highest priority first.
  logic         special;
  logic [W-1:0] spec_res;
  logic [4:0]   spec_exc;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    special  = 1'b1;
    spec_res = '0;
    spec_exc = '0;
    if (cls_a.is_nan | cls_b.is_nan | (cls_a.is_zero & cls_b.is_zero) |
        (cls_a.is_inf & cls_b.is_inf)) begin
      spec_res              = QNAN;
      spec_exc[EXC_INVALID] = 1'b1;
    end else if (cls_b.is_zero) begin
      spec_res               = {sign_ab, INF_MAG};
      spec_exc[EXC_DIV_ZERO] = 1'b1;
    end else if (cls_a.is_inf) begin
      spec_res = {sign_ab, INF_MAG};
    end else if (cls_b.is_inf | cls_a.is_zero) begin
      spec_res = {sign_ab, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring-division step: subtract the divisor when it fits.
  logic             ge;
  logic [MAN_W+1:0] rem_sel;

  assign ge      = rem >= {1'b0, mb};
  assign rem_sel = ge ? rem - {1'b0, mb} : rem;

  // Normalise quotient, round to nearest even, then range-check the exponent.
  logic [QW-1:0]        q_norm;
  logic signed [EW-1:0] e_adj, e_fin;
  logic                 g_bit, r_bit, s_bit, round_up, inexact;
  logic [MAN_W+1:0]     mant_sum;
  logic [MAN_W-1:0]     frac_fin;
  logic [W-1:0]         rnd_res;
  logic [4:0]           rnd_exc;

  always_comb begin
    q_norm = quo;
    e_adj  = e_q;
    if (!quo[QW-1]) begin
      q_norm = quo << 1;
      e_adj  = e_q - E_ONE;
    end
    g_bit    = q_norm[2];
    r_bit    = q_norm[1];
    s_bit    = q_norm[0] | (rem != '0);
    inexact  = g_bit | r_bit | s_bit;
    round_up = g_bit & (r_bit | s_bit | q_norm[3]);
    mant_sum = {1'b0, q_norm[QW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    e_fin    = e_adj;
    frac_fin = mant_sum[MAN_W-1:0];
    if (mant_sum[MAN_W+1]) begin
      e_fin    = e_adj + E_ONE;
      frac_fin = mant_sum[MAN_W:1];
    end
    rnd_res = '0;
    rnd_exc = '0;
    if (e_fin >= E_MAX) begin
      rnd_res                = {sign_q, INF_MAG};
      rnd_exc[EXC_OVERFLOW]  = 1'b1;
      rnd_exc[EXC_INEXACT]   = 1'b1;
    end else if (e_fin <= E_ZERO) begin
      rnd_res                = {sign_q, {(W-1){1'b0}}};
      rnd_exc[EXC_UNDERFLOW] = 1'b1;
      rnd_exc[EXC_INEXACT]   = 1'b1;
    end else begin
      rnd_res              = {sign_q, e_fin[EXP_W-1:0], frac_fin};
      rnd_exc[EXC_INEXACT] = inexact;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sign_q <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      ea     <= '0;
      eb     <= '0;
      e_q    <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      res_q  <= '0;
      exc_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            a_q    <= bus.InputA;
            b_q    <= bus.InputB;
            busy_q <= 1'b1;
            state  <= ST_CLASSIFY;
          end
        end
        ST_CLASSIFY: begin
          sign_q <= sign_ab;
          if (special) begin
            res_q  <= spec_res;
            exc_q  <= spec_exc;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            // Subnormals use effective exponent 1 with a clear hidden bit.
            ma    <= {~cls_a.is_sub, a_q[MAN_W-1:0]};
            mb    <= {~cls_b.is_sub, b_q[MAN_W-1:0]};
            ea    <= cls_a.is_sub ? E_ONE : $signed({2'b00, a_q[W-2:MAN_W]});
            eb    <= cls_b.is_sub ? E_ONE : $signed({2'b00, b_q[W-2:MAN_W]});
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (ma[MAN_W] && mb[MAN_W]) begin
            e_q   <= ea - eb + BIAS;
            rem   <= {1'b0, ma};
            quo   <= '0;
            cnt   <= '0;
            state <= ST_DIVIDE;
          end else begin
            if (!ma[MAN_W]) begin
              ma <= ma << 1;
              ea <= ea - E_ONE;
            end
            if (!mb[MAN_W]) begin
              mb <= mb << 1;
              eb <= eb - E_ONE;
            end
          end
        end
        ST_DIVIDE: begin
          quo <= {quo[QW-2:0], ge};
          rem <= rem_sel << 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= ST_ROUND;
        end
        ST_ROUND: begin
          res_q  <= rnd_res;
          exc_q  <= rnd_exc;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.AbyB      = res_q;
  assign bus.EXCEPTION = exc_q;
  assign bus.DONE      = done_q;
  assign bus.BUSY      = busy_q;
endmodule

// File: tb/tb_fpdiv_param.sv
// Scoreboard bench for fpdiv_param (single precision): directed spec cases plus
// random operands checked against an exact rational-arithmetic reference model.
module tb_fpdiv_param;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  exc;
    int          lat;
    int          start;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst_n;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  sb_item_t    sb[$];
  sb_item_t    mon_item;
  logic [31:0] last_res;
  logic [4:0]  last_exc;

  fpdiv_param_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fpdiv_param #(.EXP_W(8), .MAN_W(23)) dut (
    .CLOCK  (clk),
    .RESET_N(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  function automatic int lead_zeros24(input longint v);
    for (int i = 23; i >= 0; i--)
      if (((v >> i) & 1) != 0) return 23 - i;
    return 24;
  endfunction

  // Exact quotient of the two significands, rounded to 24 bits with ties to even.
  function automatic sb_item_t model(input logic [31:0] a, input logic [31:0] b);
    sb_item_t r;
    logic     s;
    int       xa, xb, e, be;
    longint   fa, fb, num, den, sig, rm;
    bit       nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, inx;
    s  = a[31] ^ b[31];
    xa = int'(a[30:23]);
    xb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    nan_a  = (xa == 255) && (fa != 0);
    nan_b  = (xb == 255) && (fb != 0);
    inf_a  = (xa == 255) && (fa == 0);
    inf_b  = (xb == 255) && (fb == 0);
    zero_a = (xa == 0) && (fa == 0);
    zero_b = (xb == 0) && (fb == 0);
    r.start = 0;
    r.lat   = 1;
    r.exc   = 5'b00000;
    r.res   = 32'h0;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      r.res = 32'h7FC00000;
      r.exc = 5'b10000;
    end else if (zero_b) begin
      r.res = {s, 31'h7F800000};
      r.exc = 5'b01000;
    end else if (inf_a) begin
      r.res = {s, 31'h7F800000};
    end else if (inf_b || zero_a) begin
      r.res = {s, 31'h0};
    end else begin
      num = (xa == 0) ? fa : (fa | (64'd1 << 23));
      den = (xb == 0) ? fb : (fb | (64'd1 << 23));
      e   = ((xa == 0) ? 1 : xa) - ((xb == 0) ? 1 : xb);
      r.lat = 30 + ((lead_zeros24(num) > lead_zeros24(den)) ? lead_zeros24(num)
                                                            : lead_zeros24(den));
      while (num < den) begin num = num * 2; e--; end
      while (num >= 2 * den) begin den = den * 2; e++; end
      sig = (num << 23) / den;
      rm  = (num << 23) % den;
      inx = (rm != 0);
      if ((2 * rm > den) || ((2 * rm == den) && ((sig & 1) != 0))) sig++;
      if (sig == (64'd1 << 24)) begin sig = sig >> 1; e++; end
      be = e + 127;
      if (be >= 255) begin
        r.res = {s, 31'h7F800000};
        r.exc = 5'b00101;
      end else if (be <= 0) begin
        r.res = {s, 31'h0};
        r.exc = 5'b00011;
      end else begin
        r.res = {s, 8'(be), 23'(sig)};
        r.exc = {4'b0000, inx};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 11))
      0:       v[30:0]  = '0;
      1:       v[30:23] = 8'h00;
      2:       v[30:0]  = 31'h7F800000;
      3:       v[30:23] = 8'hFF;
      4:       v[30:23] = 8'($urandom_range(1, 254));
      5: begin
        v[30:23] = 8'($urandom_range(120, 134));
        v[22:0]  = v[22:0] & 23'h7F0000;
      end
      default: v[30:23] = 8'($urandom_range(90, 164));
    endcase
    return v;
  endfunction

  // Wait (bounded) for an idle DUT, present one request, log it once accepted.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input sb_item_t item, output bit in_done);
    sb_item_t it;
    int       waited;
    it     = item;
    waited = 0;
    @(negedge clk);
    while (bus.BUSY && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (bus.BUSY) check("busy_timeout", 64'(bus.BUSY), 64'd0);
    in_done    = bus.DONE;
    bus.START  = 1'b1;
    bus.InputA = a;
    bus.InputB = b;
    @(posedge clk);
    #1;
    it.start = edge_cnt;
    sb.push_back(it);
    bus.START = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  // Monitor: pop on DONE; between DONEs outputs must hold and BUSY must cover flight.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_res = '0;
      last_exc = '0;
    end else if (bus.DONE) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(bus.DONE), 64'd0);
      end else begin
        mon_item = sb.pop_front();
        check("result", 64'(bus.AbyB), 64'(mon_item.res));
        check("exception", 64'(bus.EXCEPTION), 64'(mon_item.exc));
        check("latency", 64'(edge_cnt - mon_item.start), 64'(mon_item.lat));
      end
      last_res = bus.AbyB;
      last_exc = bus.EXCEPTION;
    end else begin
      check("result_hold", 64'(bus.AbyB), 64'(last_res));
      check("exception_hold", 64'(bus.EXCEPTION), 64'(last_exc));
      if (sb.size() != 0) check("busy_in_flight", 64'(bus.BUSY), 64'd1);
    end
  end

  logic [31:0] dir_a   [9] = '{32'h40C00000, 32'h3F800000, 32'h41200000,
                               32'h3F800000, 32'h00000000, 32'h7F800000,
                               32'h7F000000, 32'h00800000, 32'h00400000};
  logic [31:0] dir_b   [9] = '{32'h40000000, 32'h40400000, 32'h40A00000,
                               32'h00000000, 32'h00000000, 32'h7F800000,
                               32'h3E800000, 32'h4B000000, 32'h00800000};
  logic [31:0] dir_res [9] = '{32'h40400000, 32'h3EAAAAAB, 32'h40000000,
                               32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                               32'h7F800000, 32'h00000000, 32'h3F000000};
  logic [4:0]  dir_exc [9] = '{5'b00000, 5'b00001, 5'b00000,
                               5'b01000, 5'b10000, 5'b10000,
                               5'b00101, 5'b00011, 5'b00000};
  int          dir_lat [9] = '{30, 30, 30, 1, 1, 1, 30, 30, 31};

  initial begin
    sb_item_t    item;
    bit          in_done;
    logic [31:0] a, b;

    bus.START  = 1'b0;
    bus.InputA = '0;
    bus.InputB = '0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_abyb", 64'(bus.AbyB), 64'd0);
    check("reset_done", 64'(bus.DONE), 64'd0);
    check("reset_busy", 64'(bus.BUSY), 64'd0);
    check("reset_exception", 64'(bus.EXCEPTION), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases issued back to back; each START lands in the previous DONE cycle.
    for (int i = 0; i < 9; i++) begin
      item.res   = dir_res[i];
      item.exc   = dir_exc[i];
      item.lat   = dir_lat[i];
      item.start = 0;
      issue(dir_a[i], dir_b[i], item, in_done);
      if (i == 2) check("start_in_done_cycle", 64'(in_done), 64'd1);
    end
    drain();

    // START while busy must be ignored and leave the in-flight result untouched.
    item.res = 32'h40400000;
    item.exc = 5'b00000;
    item.lat = 30;
    issue(32'h40C00000, 32'h40000000, item, in_done);
    repeat (5) @(negedge clk);
    bus.START  = 1'b1;
    bus.InputA = 32'h3F800000;
    bus.InputB = 32'h00000000;
    @(negedge clk);
    bus.START = 1'b0;
    drain();

    // Reset ten edges into a division: outputs clear at once, no DONE follows.
    issue(32'h3F800000, 32'h40400000, model(32'h3F800000, 32'h40400000), in_done);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midreset_abyb", 64'(bus.AbyB), 64'd0);
    check("midreset_done", 64'(bus.DONE), 64'd0);
    check("midreset_busy", 64'(bus.BUSY), 64'd0);
    check("midreset_exception", 64'(bus.EXCEPTION), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);

    // Random operands against the reference model.
    for (int i = 0; i < 150; i++) begin
      a = rand_op();
      b = rand_op();
      issue(a, b, model(a, b), in_done);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
